punc_control: RTL and testbench
===============================

PUNC_CONTROL -- requirements
Module: punc_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, ports clk and rst; all state changes occur on clk rising edge.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 sync reset; ir in 16 current instruction; nzp_true in 1 branch condition met.
REQ-003 SHALL have outputs: pc_ld, pc_clr, pc_inc out 1 each; pc_sel out 2 (0 PC+sext(ir[8:0]), 1 PC+sext(ir[10:0]), 2 RF R1 data).
REQ-004 SHALL have outputs: ir_ld, ir_clr, mem_rd, mem_wr out 1 each; mem_r_addr_sel out 2 (0 PC, 1 PC+off9, 2 R0 data, 3 R1+off6); mem_w_addr_sel out 2 (0 PC+off9, 1 prev, 2 R1+off6).
REQ-005 SHALL have outputs: rf_w_data_sel out 2 (0 ALU, 1 PC+off9, 2 mem read, 3 PC); rf_w_addr_sel out 1 (0 R7, 1 ir[11:9]); rf_w_wr, rf_r0_rd, rf_r1_rd out 1; rf_r0_addr_sel out 1 (0 ir[11:9], 1 ir[2:0]).
REQ-006 SHALL have outputs: prev_ld, nzp_ld, nzp_clr out 1; alu_sel out 2 (0 passA, 1 add, 2 and, 3 notB); alu_first_val_sel out 1 (0 R0 data, 1 sext(ir[4:0])).

Function
REQ-007 SHALL implement states FETCH, DECODE, EXEC, EXEC2, HALT; all outputs combinational from state, ir, nzp_true; every unlisted output is 0.
REQ-008 FETCH SHALL assert mem_rd, mem_r_addr_sel=0, ir_ld, pc_inc; next DECODE.
REQ-009 DECODE SHALL assert no outputs; next HALT if ir[15:12]=1111, else EXEC.
REQ-010 EXEC ADD/AND (0001/0101): rf_w_wr, rf_w_addr_sel=1, rf_w_data_sel=0, nzp_ld, alu_sel=1/2, rf_r0_addr_sel=1 and alu_first_val_sel=0 if ir[5]=0, else alu_first_val_sel=1; NOT (1001): alu_sel=3, same write/nzp.
REQ-011 EXEC LD (0010): mem_rd, mem_r_addr_sel=1, rf_w_data_sel=2, rf_w_addr_sel=1, rf_w_wr, nzp_ld; LDR (0110): same with mem_r_addr_sel=3; LEA (1110): rf_w_data_sel=1, write DR, nzp_ld.
REQ-012 EXEC ST (0011): mem_wr, mem_w_addr_sel=0, rf_r0_addr_sel=0; STR (0111): same with mem_w_addr_sel=2.
REQ-013 LDI (1010) SHALL take two cycles: EXEC as LD but nzp_ld=0; EXEC2 mem_rd, mem_r_addr_sel=2, rf_r0_addr_sel=0, rf_w_data_sel=2, write DR, nzp_ld.
REQ-014 STI (1011) SHALL take two cycles: EXEC prev_ld, mem_rd, mem_r_addr_sel=1; EXEC2 mem_wr, mem_w_addr_sel=1, rf_r0_addr_sel=0.
REQ-015 BR (0000): pc_ld=nzp_true, pc_sel=0; JMP/RET (1100): pc_ld, pc_sel=2.
REQ-016 JSR/JSRR (0100): rf_w_wr, rf_w_addr_sel=0, rf_w_data_sel=3, pc_ld, pc_sel=1 if ir[11]=1 else 2; both writes use pre-edge PC and R1 (JSRR R7 base reads old R7).
REQ-017 From EXEC (single-cycle ops) and EXEC2 next state SHALL be FETCH; LDI/STI EXEC goes to EXEC2.
REQ-018 HALT SHALL assert no outputs and remain until rst.
REQ-019 pc_inc and pc_ld SHALL never be asserted in the same cycle.
REQ-020 Opcodes 1000 and 1101 handled per REQ-024.

Reset
REQ-021 rst=1 SHALL force next state FETCH and, during that cycle, assert pc_clr, ir_clr, nzp_clr with all other outputs 0, overriding any state including HALT or EXEC2.
REQ-022 Reset mid-LDI/STI SHALL abandon EXEC2; no mem_wr in the reset cycle.

Configuration
REQ-023 Macro PUNC_ILLEGAL_HALT_EN SHALL select illegal-opcode handling.
REQ-024 Defined: DECODE sends 1000/1101 to HALT; undefined: they execute as NOP in EXEC (no outputs) and return to FETCH.

Verification
REQ-025 Reset then ir=0x1261 (ADD R1,R1,#1): FETCH/DECODE/EXEC; EXEC shows rf_w_wr=1, alu_sel=1, alu_first_val_sel=1, nzp_ld=1; back to FETCH.
REQ-026 ir=0x0E02 (BRnzp) nzp_true=1: EXEC pc_ld=1, pc_sel=0; with ir=0x0802, nzp_true=0: pc_ld=0.
REQ-027 ir=0xB603 (STI R3): EXEC prev_ld=1, mem_r_addr_sel=1; EXEC2 mem_wr=1, mem_w_addr_sel=1; 4 cycles total.
REQ-028 ir=0x4802 (JSR): EXEC rf_w_addr_sel=0, rf_w_data_sel=3, pc_ld=1, pc_sel=1; ir=0x4080 (JSRR R2): pc_sel=2.
REQ-029 ir=0xF025 (HALT): stays HALT 10+ cycles, all outputs 0; rst=1 -> pc_clr=ir_clr=nzp_clr=1, then FETCH.
REQ-030 ir=0xD000: with macro, HALT after DECODE; without, EXEC all outputs 0 then FETCH.

Source files
------------

// File: rtl/punc_control.sv
// Main control FSM for the PUNC datapath: FETCH/DECODE/EXEC/EXEC2/HALT.
// Define PUNC_ILLEGAL_HALT_EN to halt on reserved opcodes 1000/1101; otherwise they run as NOPs.
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        nzp_true,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        ir_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_r_addr_sel,
  output logic [1:0]  mem_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        rf_w_wr,
  output logic        rf_r0_rd,
  output logic        rf_r1_rd,
  output logic        rf_r0_addr_sel,
  output logic        prev_ld,
  output logic        nzp_ld,
  output logic        nzp_clr,
  output logic [1:0]  alu_sel,
  output logic        alu_first_val_sel
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    EXEC2  = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RES8 = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RESD = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] opcode_s;
  logic       illegal_halt_s;
  logic       unused_ir_s;

  assign opcode_s    = ir[15:12];
  assign unused_ir_s = ^{ir[10:6], ir[4:0]};

`ifdef PUNC_ILLEGAL_HALT_EN
  assign illegal_halt_s = (opcode_s == OP_RES8) || (opcode_s == OP_RESD);
`else
  assign illegal_halt_s = 1'b0;
`endif

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode; reset overrides every state.
  always_comb begin
    next_state_s      = state_r;
    pc_ld             = 1'b0;
    pc_clr            = 1'b0;
    pc_inc            = 1'b0;
    pc_sel            = 2'd0;
    ir_ld             = 1'b0;
    ir_clr            = 1'b0;
    mem_rd            = 1'b0;
    mem_wr            = 1'b0;
    mem_r_addr_sel    = 2'd0;
    mem_w_addr_sel    = 2'd0;
    rf_w_data_sel     = 2'd0;
    rf_w_addr_sel     = 1'b0;
    rf_w_wr           = 1'b0;
    rf_r0_rd          = 1'b0;
    rf_r1_rd          = 1'b0;
    rf_r0_addr_sel    = 1'b0;
    prev_ld           = 1'b0;
    nzp_ld            = 1'b0;
    nzp_clr           = 1'b0;
    alu_sel           = 2'd0;
    alu_first_val_sel = 1'b0;
    if (rst) begin
      next_state_s = FETCH;
      pc_clr       = 1'b1;
      ir_clr       = 1'b1;
      nzp_clr      = 1'b1;
    end else begin
      case (state_r)
        FETCH: begin
          mem_rd       = 1'b1;
          ir_ld        = 1'b1;
          pc_inc       = 1'b1;
          next_state_s = DECODE;
        end
        DECODE: begin
          if ((opcode_s == OP_HALT) || illegal_halt_s) begin
            next_state_s = HALT;
          end else begin
            next_state_s = EXEC;
          end
        end
        EXEC: begin
          next_state_s = FETCH;
          case (opcode_s)
            OP_ADD, OP_AND: begin
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
              alu_sel       = (opcode_s == OP_ADD) ? 2'd1 : 2'd2;
              if (ir[5]) begin
                alu_first_val_sel = 1'b1;
              end else begin
                rf_r0_addr_sel = 1'b1;
              end
            end
            OP_NOT: begin
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
              alu_sel       = 2'd3;
            end
            OP_LD, OP_LDR, OP_LDI: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = (opcode_s == OP_LDR) ? 2'd3 : 2'd1;
              rf_w_data_sel  = 2'd2;
              rf_w_addr_sel  = 1'b1;
              rf_w_wr        = 1'b1;
              // LDI only loads the pointer here; flags follow the final data in EXEC2.
              nzp_ld         = (opcode_s != OP_LDI);
              if (opcode_s == OP_LDI) begin
                next_state_s = EXEC2;
              end else begin
                next_state_s = FETCH;
              end
            end
            OP_LEA: begin
              rf_w_data_sel = 2'd1;
              rf_w_addr_sel = 1'b1;
              rf_w_wr       = 1'b1;
              nzp_ld        = 1'b1;
            end
            OP_ST, OP_STR: begin
              mem_wr         = 1'b1;
              mem_w_addr_sel = (opcode_s == OP_STR) ? 2'd2 : 2'd0;
            end
            OP_STI: begin
              prev_ld        = 1'b1;
              mem_rd         = 1'b1;
              mem_r_addr_sel = 2'd1;
              next_state_s   = EXEC2;
            end
            OP_BR: begin
              pc_ld = nzp_true;
            end
            OP_JMP: begin
              pc_ld  = 1'b1;
              pc_sel = 2'd2;
            end
            OP_JSR: begin
              rf_w_wr       = 1'b1;
              rf_w_data_sel = 2'd3;
              pc_ld         = 1'b1;
              pc_sel        = ir[11] ? 2'd1 : 2'd2;
            end
            default: begin
              next_state_s = FETCH;
            end
          endcase
        end
        EXEC2: begin
          next_state_s = FETCH;
          case (opcode_s)
            OP_LDI: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = 2'd2;
              rf_w_data_sel  = 2'd2;
              rf_w_addr_sel  = 1'b1;
              rf_w_wr        = 1'b1;
              nzp_ld         = 1'b1;
            end
            OP_STI: begin
              mem_wr         = 1'b1;
              mem_w_addr_sel = 2'd1;
            end
            default: begin
              next_state_s = FETCH;
            end
          endcase
        end
        HALT: begin
          next_state_s = HALT;
        end
        default: begin
          next_state_s = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: directed literal checks plus randomized instruction streams
// compared every cycle against an instruction-level reference model.
module tb_punc_control;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       ir_clr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_r_addr_sel;
    logic [1:0] mem_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       rf_w_wr;
    logic       rf_r0_rd;
    logic       rf_r1_rd;
    logic       rf_r0_addr_sel;
    logic       prev_ld;
    logic       nzp_ld;
    logic       nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_first_val_sel;
  } outs_t;

`ifdef PUNC_ILLEGAL_HALT_EN
  localparam bit ILL_HALT = 1'b1;
`else
  localparam bit ILL_HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        nzp_true = 1'b0;
  logic        pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, mem_rd, mem_wr;
  logic [1:0]  pc_sel, mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, alu_sel;
  logic        rf_w_addr_sel, rf_w_wr, rf_r0_rd, rf_r1_rd, rf_r0_addr_sel;
  logic        prev_ld, nzp_ld, nzp_clr, alu_first_val_sel;
  outs_t       act;

  int n_chk = 0;
  int n_err = 0;

  // Model: cycle index inside the current instruction (0 fetch, 1 decode, 2 first execute, 3 second execute)
  int m_step = 0;
  bit m_halt = 1'b0;

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
    .rf_r0_rd(rf_r0_rd), .rf_r1_rd(rf_r1_rd), .rf_r0_addr_sel(rf_r0_addr_sel),
    .prev_ld(prev_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr),
    .alu_sel(alu_sel), .alu_first_val_sel(alu_first_val_sel)
  );

  assign act = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
                mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
                rf_r0_rd, rf_r1_rd, rf_r0_addr_sel, prev_ld, nzp_ld, nzp_clr,
                alu_sel, alu_first_val_sel};

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, a, e);
    end
  endtask

  // Instruction-level reference: which micro-operations each opcode needs at each cycle.
  function automatic outs_t model_out(int step, bit halted, logic [15:0] i, logic n, logic r);
    outs_t o;
    logic [3:0] op;
    o  = '0;
    op = i[15:12];
    if (r) begin
      o.pc_clr = 1'b1; o.ir_clr = 1'b1; o.nzp_clr = 1'b1;
    end else if (!halted && step == 0) begin
      o.mem_rd = 1'b1; o.ir_ld = 1'b1; o.pc_inc = 1'b1;
    end else if (!halted && step == 2) begin
      case (op)
        4'h1, 4'h5, 4'h9: begin
          o.rf_w_wr = 1'b1; o.rf_w_addr_sel = 1'b1; o.nzp_ld = 1'b1;
          o.alu_sel = (op == 4'h1) ? 2'd1 : ((op == 4'h5) ? 2'd2 : 2'd3);
          if (op != 4'h9) begin
            o.alu_first_val_sel = i[5];
            o.rf_r0_addr_sel    = ~i[5];
          end
        end
        4'h2, 4'h6, 4'hA: begin
          o.mem_rd = 1'b1; o.mem_r_addr_sel = (op == 4'h6) ? 2'd3 : 2'd1;
          o.rf_w_data_sel = 2'd2; o.rf_w_addr_sel = 1'b1; o.rf_w_wr = 1'b1;
          o.nzp_ld = (op != 4'hA);
        end
        4'hE: begin
          o.rf_w_data_sel = 2'd1; o.rf_w_addr_sel = 1'b1; o.rf_w_wr = 1'b1; o.nzp_ld = 1'b1;
        end
        4'h3, 4'h7: begin
          o.mem_wr = 1'b1; o.mem_w_addr_sel = (op == 4'h7) ? 2'd2 : 2'd0;
        end
        4'hB: begin
          o.prev_ld = 1'b1; o.mem_rd = 1'b1; o.mem_r_addr_sel = 2'd1;
        end
        4'h0: o.pc_ld = n;
        4'hC: begin o.pc_ld = 1'b1; o.pc_sel = 2'd2; end
        4'h4: begin
          o.rf_w_wr = 1'b1; o.rf_w_data_sel = 2'd3; o.pc_ld = 1'b1;
          o.pc_sel = i[11] ? 2'd1 : 2'd2;
        end
        default: o = '0;
      endcase
    end else if (!halted && step == 3 && op == 4'hA) begin
      o.mem_rd = 1'b1; o.mem_r_addr_sel = 2'd2; o.rf_w_data_sel = 2'd2;
      o.rf_w_addr_sel = 1'b1; o.rf_w_wr = 1'b1; o.nzp_ld = 1'b1;
    end else if (!halted && step == 3 && op == 4'hB) begin
      o.mem_wr = 1'b1; o.mem_w_addr_sel = 2'd1;
    end
    return o;
  endfunction

  // Per-cycle compare against the model, then advance the model to the next cycle.
  always @(negedge clk) begin
    outs_t e;
    logic [3:0] op;
    op = ir[15:12];
    e  = model_out(m_step, m_halt, ir, nzp_true, rst);
    check("cycle_outputs", 32'(act), 32'(e));
    check("pc_inc_pc_ld_exclusive", {31'd0, pc_inc & pc_ld}, 32'd0);
    if (rst) begin
      m_step <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt) begin
      if (m_step == 1 && (op == 4'hF || (ILL_HALT && (op == 4'h8 || op == 4'hD))))
        m_halt <= 1'b1;
      else if (m_step == 2 && (op == 4'hA || op == 4'hB))
        m_step <= 3;
      else if (m_step >= 2)
        m_step <= 0;
      else
        m_step <= m_step + 1;
    end
  end

  // Drive a new input set just after a rising edge and let it settle.
  task automatic cyc(input logic [15:0] i, input logic n, input logic r);
    @(posedge clk);
    #1;
    ir = i; nzp_true = n; rst = r;
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] rnd;
    // Reset cycle
    cyc(16'h0000, 1'b0, 1'b1);
    check("rst_pc_clr", 32'(pc_clr), 32'd1);
    check("rst_ir_clr", 32'(ir_clr), 32'd1);
    check("rst_nzp_clr", 32'(nzp_clr), 32'd1);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    // ADD R1,R1,#1
    cyc(16'h1261, 1'b0, 1'b0);
    check("fetch_mem_rd", 32'(mem_rd), 32'd1);
    check("fetch_pc_inc", 32'(pc_inc), 32'd1);
    cyc(16'h1261, 1'b0, 1'b0);
    check("decode_quiet", 32'(act), 32'd0);
    cyc(16'h1261, 1'b0, 1'b0);
    check("add_rf_w_wr", 32'(rf_w_wr), 32'd1);
    check("add_alu_sel", 32'(alu_sel), 32'd1);
    check("add_imm_sel", 32'(alu_first_val_sel), 32'd1);
    check("add_nzp_ld", 32'(nzp_ld), 32'd1);
    // BRnzp taken
    cyc(16'h0E02, 1'b1, 1'b0);
    check("back_to_fetch", 32'(ir_ld), 32'd1);
    cyc(16'h0E02, 1'b1, 1'b0);
    cyc(16'h0E02, 1'b1, 1'b0);
    check("br_taken_pc_ld", 32'(pc_ld), 32'd1);
    check("br_pc_sel", 32'(pc_sel), 32'd0);
    // BRn not taken
    cyc(16'h0802, 1'b0, 1'b0);
    cyc(16'h0802, 1'b0, 1'b0);
    cyc(16'h0802, 1'b0, 1'b0);
    check("br_not_taken", 32'(pc_ld), 32'd0);
    // STI R3: four cycles
    cyc(16'hB603, 1'b0, 1'b0);
    cyc(16'hB603, 1'b0, 1'b0);
    cyc(16'hB603, 1'b0, 1'b0);
    check("sti_prev_ld", 32'(prev_ld), 32'd1);
    check("sti_r_addr_sel", 32'(mem_r_addr_sel), 32'd1);
    cyc(16'hB603, 1'b0, 1'b0);
    check("sti_exec2_mem_wr", 32'(mem_wr), 32'd1);
    check("sti_w_addr_sel", 32'(mem_w_addr_sel), 32'd1);
    // STI again, reset lands on EXEC2
    cyc(16'hB603, 1'b0, 1'b0);
    check("sti_done_fetch", 32'(ir_ld), 32'd1);
    cyc(16'hB603, 1'b0, 1'b0);
    cyc(16'hB603, 1'b0, 1'b0);
    cyc(16'hB603, 1'b0, 1'b1);
    check("rst_exec2_no_wr", 32'(mem_wr), 32'd0);
    check("rst_exec2_pc_clr", 32'(pc_clr), 32'd1);
    // JSR
    cyc(16'h4802, 1'b0, 1'b0);
    check("after_rst_fetch", 32'(ir_ld), 32'd1);
    cyc(16'h4802, 1'b0, 1'b0);
    cyc(16'h4802, 1'b0, 1'b0);
    check("jsr_w_addr_sel", 32'(rf_w_addr_sel), 32'd0);
    check("jsr_w_data_sel", 32'(rf_w_data_sel), 32'd3);
    check("jsr_pc_ld", 32'(pc_ld), 32'd1);
    check("jsr_pc_sel", 32'(pc_sel), 32'd1);
    // JSRR R2
    cyc(16'h4080, 1'b0, 1'b0);
    cyc(16'h4080, 1'b0, 1'b0);
    cyc(16'h4080, 1'b0, 1'b0);
    check("jsrr_pc_sel", 32'(pc_sel), 32'd2);
    // HALT
    cyc(16'hF025, 1'b0, 1'b0);
    cyc(16'hF025, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(16'hF025, 1'b1, 1'b0);
      check("halt_quiet", 32'(act), 32'd0);
    end
    cyc(16'hF025, 1'b0, 1'b1);
    check("halt_rst_pc_clr", 32'(pc_clr), 32'd1);
    check("halt_rst_ir_clr", 32'(ir_clr), 32'd1);
    check("halt_rst_nzp_clr", 32'(nzp_clr), 32'd1);
    // Reserved opcode 1101
    cyc(16'hD000, 1'b0, 1'b0);
    check("halt_exit_fetch", 32'(ir_ld), 32'd1);
    cyc(16'hD000, 1'b0, 1'b0);
    cyc(16'hD000, 1'b1, 1'b0);
    check("reserved_quiet", 32'(act), 32'd0);
    cyc(16'hD000, 1'b1, 1'b0);
`ifdef PUNC_ILLEGAL_HALT_EN
    check("reserved_halts", 32'(act), 32'd0);
`else
    check("reserved_nop_fetch", 32'(ir_ld), 32'd1);
`endif
    // Randomized instruction stream; the model decides instruction boundaries.
    for (int c = 0; c < 4000; c++) begin
      rnd = 16'($urandom);
      if (m_step == 0 && !m_halt) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hA;
        rnd = {op, rnd[11:0]};
      end else begin
        rnd = ir;
      end
      if (m_halt)
        cyc(rnd, 1'($urandom), ($urandom_range(0, 3) == 0));
      else
        cyc(rnd, 1'($urandom), ($urandom_range(0, 49) == 0));
    end
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
